// File: rtl/pq_pkg.sv
// Shared types for the priority-queue subsystem: payload format, queue sizing,
// arbiter operation codes and the arbiter FSM states.
package pq_pkg;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam logic [KEY_W-1:0] KEYMAX = '1;
  localparam int PQ_CAPACITY = 8;
  localparam int PQ_NUM_REQ = 4;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ENQ,
    OP_DEQ,
    OP_REPL
  } pq_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  // Both request bits together mean replace; neither means no request at all.
  function automatic pq_op_t decode_op(input logic enq, input logic deq);
    pq_op_t op;
    op = OP_NONE;
    if (enq && deq) begin
      op = OP_REPL;
    end else if (enq) begin
      op = OP_ENQ;
    end else if (deq) begin
      op = OP_DEQ;
    end
    return op;
  endfunction

endpackage

// File: rtl/pq_if.sv
// Strobe/status bundle between a queue user (master) and the priority queue (slave).
interface pq_if;
  import pq_pkg::*;

  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic full;
  logic empty;
  logic busy;

  modport master (
    output enq, deq, kvi,
    input  kvo, full, empty, busy
  );

  modport slave (
    input  enq, deq, kvi,
    output kvo, full, empty, busy
  );

endinterface

// File: rtl/pq_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest eligible index at or above ptr,
// falling back to the lowest eligible index overall when nothing lies above.
module rr_pick
  import pq_pkg::*;
#(
  parameter int N  = PQ_NUM_REQ,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [N-1:0] masked;
  logic [N-1:0] pick_hi;
  logic [N-1:0] pick_lo;
  logic         found_hi;
  logic         found_lo;

  always_comb begin
    masked   = '0;
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < N; i++) begin
      masked[i] = elig[i] && (i >= int'(ptr));
    end
    for (int i = 0; i < N; i++) begin
      if (masked[i] && !found_hi) begin
        pick_hi[i] = 1'b1;
        found_hi   = 1'b1;
      end
      if (elig[i] && !found_lo) begin
        pick_lo[i] = 1'b1;
        found_lo   = 1'b1;
      end
    end
    pick  = found_hi ? pick_hi : pick_lo;
    valid = |elig;
  end

endmodule

// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one priority queue among N requesters; issues one
// queue operation at a time and returns dequeued heads to the granted requester.
module pq_arbiter
  import pq_pkg::*;
#(
  parameter int N = PQ_NUM_REQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_enq,
  input  logic [N-1:0]      req_deq,
  input  kv_t  [N-1:0]      req_kv,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      rsp_valid,
  output kv_t               rsp_kv,
  pq_if.master              pq
);

  localparam int PW = $clog2(N);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  pq_op_t        op_q, op_d;
  logic [N-1:0]  sel_q, sel_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  rsp_valid_q, rsp_valid_d;
  kv_t           rsp_kv_q, rsp_kv_d;
  kv_t           kvi_q, kvi_d;
  logic          enq_q, enq_d;
  logic          deq_q, deq_d;

  pq_op_t        req_op [N];
  logic [N-1:0]  elig;
  logic [N-1:0]  pick;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  // Status flags only matter while idle; an ineligible request simply waits.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      req_op[i] = decode_op(req_enq[i], req_deq[i]);
      unique case (req_op[i])
        OP_ENQ:          elig[i] = !pq.full;
        OP_DEQ, OP_REPL: elig[i] = !pq.empty;
        default:         elig[i] = 1'b0;
      endcase
      elig[i] = elig[i] && !pq.busy;
    end
  end

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    op_d        = op_q;
    sel_d       = sel_q;
    rsp_kv_d    = rsp_kv_q;
    kvi_d       = kvi_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    enq_d       = 1'b0;
    deq_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          sel_d   = pick;
          op_d    = req_op[pick_idx];
          kvi_d   = req_kv[pick_idx];
          gnt_d   = pick;
          enq_d   = (req_op[pick_idx] == OP_ENQ) || (req_op[pick_idx] == OP_REPL);
          deq_d   = (req_op[pick_idx] == OP_DEQ) || (req_op[pick_idx] == OP_REPL);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The head seen while the strobe is up is the entry being removed.
        if (op_q == OP_DEQ || op_q == OP_REPL) begin
          rsp_kv_d    = pq.kvo;
          rsp_valid_d = sel_q;
        end
        ptr_d   = (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (!pq.busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      op_q        <= OP_NONE;
      sel_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_kv_q    <= '0;
      kvi_q       <= '0;
      enq_q       <= 1'b0;
      deq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      op_q        <= op_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_kv_q    <= rsp_kv_d;
      kvi_q       <= kvi_d;
      enq_q       <= enq_d;
      deq_q       <= deq_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_kv    = rsp_kv_q;
  assign pq.enq    = enq_q;
  assign pq.deq    = deq_q;
  assign pq.kvi    = kvi_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// Bench for pq_arbiter: a behavioural sorted queue sits on the slave side and a
// scoreboard of expected grants/responses is matched against DUT pulses.
module tb_pq_arbiter;
  import pq_pkg::*;

  localparam int N = PQ_NUM_REQ;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_enq;
  logic [N-1:0] req_deq;
  kv_t  [N-1:0] req_kv;
  logic [N-1:0] gnt;
  logic [N-1:0] rsp_valid;
  kv_t          rsp_kv;

  pq_if pq ();

  pq_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_enq   (req_enq),
    .req_deq   (req_deq),
    .req_kv    (req_kv),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_kv    (rsp_kv),
    .pq        (pq.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic enq;
    logic deq;
    int   key;
  } gnt_exp_t;

  typedef struct {
    int idx;
    int key;
  } rsp_exp_t;

  gnt_exp_t exp_gnt [$];
  rsp_exp_t exp_rsp [$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_gnt_cycle = -1;
  bit rate_en = 1'b0;

  kv_t mem [$];
  int  busy_cnt = 0;
  int  busy_len = 1;
  int  ins_pos;

  // Behavioural queue: ascending keys, head at index 0, busy for busy_len cycles after an op.
  always @(posedge clk) begin
    if (rst) begin
      mem.delete();
      busy_cnt = 0;
    end else begin
      if (pq.enq || pq.deq) begin
        if (pq.deq && mem.size() > 0) begin
          void'(mem.pop_front());
        end
        if (pq.enq && mem.size() < PQ_CAPACITY) begin
          ins_pos = mem.size();
          for (int k = 0; k < mem.size(); k++) begin
            if (mem[k].key > pq.kvi.key) begin
              ins_pos = k;
              break;
            end
          end
          mem.insert(ins_pos, pq.kvi);
        end
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
      end
    end
    pq.busy  <= (busy_cnt > 0);
    pq.full  <= (mem.size() >= PQ_CAPACITY);
    pq.empty <= (mem.size() == 0);
    pq.kvo   <= (mem.size() > 0) ? mem[0] : '0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic enq, input logic deq, input int key);
    req_enq[idx]    = enq;
    req_deq[idx]    = deq;
    req_kv[idx].key = KEY_W'(key);
    req_kv[idx].val = VAL_W'(idx);
  endtask

  task automatic expect_gnt(input int idx, input logic enq, input logic deq, input int key);
    exp_gnt.push_back('{idx, enq, deq, key});
  endtask

  task automatic expect_rsp(input int idx, input int key);
    exp_rsp.push_back('{idx, key});
  endtask

  // One clock: sample at the falling edge, score pulses, retire granted requests.
  task automatic step();
    gnt_exp_t g;
    rsp_exp_t r;
    @(negedge clk);
    cycle++;
    if (gnt != '0) begin
      if (exp_gnt.size() == 0) begin
        checkOutput("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        g = exp_gnt.pop_front();
        checkOutput("gnt", 32'(gnt), 32'd1 << g.idx);
        checkOutput("pq_enq", 32'(pq.enq), 32'(g.enq));
        checkOutput("pq_deq", 32'(pq.deq), 32'(g.deq));
        if (g.enq) begin
          checkOutput("pq_kvi", 32'(pq.kvi.key), 32'(g.key));
        end
      end
      if (rate_en && last_gnt_cycle >= 0) begin
        checkOutput("gnt_spacing", 32'(cycle - last_gnt_cycle), 32'd3);
      end
      last_gnt_cycle = cycle;
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          req_enq[i] = 1'b0;
          req_deq[i] = 1'b0;
        end
      end
    end else if (pq.enq || pq.deq) begin
      checkOutput("strobe_without_gnt", {30'd0, pq.enq, pq.deq}, 32'd0);
    end
    if (rsp_valid != '0) begin
      if (exp_rsp.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        r = exp_rsp.pop_front();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1 << r.idx);
        checkOutput("rsp_kv", 32'(rsp_kv.key), 32'(r.key));
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_gnt.size() != 0 || exp_rsp.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    if (exp_gnt.size() != 0 || exp_rsp.size() != 0) begin
      checkOutput("drain_timeout", 32'(exp_gnt.size() + exp_rsp.size()), 32'd0);
      exp_gnt.delete();
      exp_rsp.delete();
    end
    for (int k = 0; k < 16 && dut.state_q != IDLE; k++) begin
      step();
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_enq = '0;
    req_deq = '0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    req_enq = '0;
    req_deq = '0;
    req_kv  = '0;

    // Reset, then ten idle cycles with every output quiet.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      checkOutput("idle_pulses", {gnt, rsp_valid, pq.enq, pq.deq}, 32'd0);
      checkOutput("idle_kv", {pq.kvi, rsp_kv}, 32'd0);
      checkOutput("idle_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("idle_ptr", 32'(dut.ptr_q), 32'd0);
    end

    // Single enqueue, then a dequeue by another requester.
    applyStimulus(2, 1'b1, 1'b0, 5);
    expect_gnt(2, 1'b1, 1'b0, 5);
    step();
    checkOutput("gnt_latency", 32'(gnt), 32'b0100);
    drain(40);
    applyStimulus(0, 1'b0, 1'b1, 0);
    expect_gnt(0, 1'b0, 1'b1, 0);
    expect_rsp(0, 5);
    step();
    step();
    checkOutput("rsp_latency", 32'(rsp_valid), 32'b0001);
    drain(40);

    // Four simultaneous enqueues at full rate, then four simultaneous dequeues.
    do_reset();
    busy_len = 0;
    rate_en  = 1'b1;
    last_gnt_cycle = -1;
    applyStimulus(0, 1'b1, 1'b0, 9);
    applyStimulus(1, 1'b1, 1'b0, 3);
    applyStimulus(2, 1'b1, 1'b0, 7);
    applyStimulus(3, 1'b1, 1'b0, 1);
    expect_gnt(0, 1'b1, 1'b0, 9);
    expect_gnt(1, 1'b1, 1'b0, 3);
    expect_gnt(2, 1'b1, 1'b0, 7);
    expect_gnt(3, 1'b1, 1'b0, 1);
    drain(60);
    rate_en  = 1'b0;
    busy_len = 1;
    for (int i = 0; i < N; i++) begin
      applyStimulus(i, 1'b0, 1'b1, 0);
      expect_gnt(i, 1'b0, 1'b1, 0);
    end
    expect_rsp(0, 1);
    expect_rsp(1, 3);
    expect_rsp(2, 7);
    expect_rsp(3, 9);
    drain(80);

    // Dequeue on an empty queue waits until someone enqueues.
    applyStimulus(1, 1'b0, 1'b1, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      checkOutput("empty_hold_gnt", 32'(gnt), 32'd0);
    end
    applyStimulus(3, 1'b1, 1'b0, 4);
    expect_gnt(3, 1'b1, 1'b0, 4);
    expect_gnt(1, 1'b0, 1'b1, 0);
    expect_rsp(1, 4);
    drain(60);

    // Fill to capacity: enqueue stalls, replace proceeds, dequeue frees a slot.
    for (int k = 0; k < PQ_CAPACITY; k++) begin
      applyStimulus(2, 1'b1, 1'b0, 10 + k);
      expect_gnt(2, 1'b1, 1'b0, 10 + k);
      drain(40);
    end
    checkOutput("queue_full", 32'(pq.full), 32'd1);
    applyStimulus(0, 1'b1, 1'b0, 20);
    applyStimulus(1, 1'b1, 1'b1, 2);
    expect_gnt(1, 1'b1, 1'b1, 2);
    expect_rsp(1, 10);
    drain(40);
    for (int c = 0; c < 6; c++) begin
      step();
      checkOutput("full_hold_gnt", 32'(gnt), 32'd0);
    end
    applyStimulus(3, 1'b0, 1'b1, 0);
    expect_gnt(3, 1'b0, 1'b1, 0);
    expect_rsp(3, 2);
    expect_gnt(0, 1'b1, 1'b0, 20);
    drain(60);

    // Reset while waiting on a busy queue.
    busy_len = 5;
    applyStimulus(2, 1'b0, 1'b1, 0);
    expect_gnt(2, 1'b0, 1'b1, 0);
    expect_rsp(2, 11);
    step();
    step();
    checkOutput("wait_busy", 32'(pq.busy), 32'd1);
    checkOutput("wait_state", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1;
    step();
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst_ptr", 32'(dut.ptr_q), 32'd0);
    checkOutput("rst_pulses", {gnt, rsp_valid, pq.enq, pq.deq}, 32'd0);
    rst = 1'b0;
    busy_len = 1;
    step();
    checkOutput("post_rst_rsp", 32'(rsp_valid), 32'd0);

    checkOutput("gnt_left", 32'(exp_gnt.size()), 32'd0);
    checkOutput("rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
